// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: programs the PLL reconfiguration controller over its
// Avalon-MM management port. It writes MODE, N, M, optional K, the selected
// C counters and then START. After that it waits for a stable PLL lock,
// bounded by a timeout.

// Per-channel holding cell: the C counter word plus a "still to be written" flag.
module pll_reconfig_seq_chan (
    input  logic        refclk,
    input  logic        rst,
    input  logic        load,
    input  logic        clr,
    input  logic [17:0] word_in,
    input  logic        mask_in,
    output logic [17:0] word,
    output logic        pend
);
    // Capture the word on request accept; pend drops once this channel's write is taken
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            word <= '0;
            pend <= 1'b0;
        end else if (load) begin
            word <= word_in;
            pend <= mask_in;
        end else if (clr) begin
            pend <= 1'b0;
        end
    end
endmodule

module pll_reconfig_seq #(
    parameter int NUM_CLK      = 1,
    parameter int FRAC_EN      = 1,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 500000
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [17:0]           req_n,
    input  logic [17:0]           req_m,
    input  logic [31:0]           req_k,
    input  logic [NUM_CLK*18-1:0] req_c,
    input  logic [NUM_CLK-1:0]    req_c_mask,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [5:0]            mgmt_address,
    output logic                  mgmt_write,
    output logic [31:0]           mgmt_writedata,
    input  logic                  mgmt_waitrequest,
    input  logic                  pll_locked,
    output logic                  cfg_locked
);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);

    localparam logic [5:0] A_MODE  = 6'h00;
    localparam logic [5:0] A_START = 6'h02;
    localparam logic [5:0] A_N     = 6'h03;
    localparam logic [5:0] A_M     = 6'h04;
    localparam logic [5:0] A_C     = 6'h05;
    localparam logic [5:0] A_K     = 6'h07;

    typedef enum logic [3:0] {
        S_IDLE, S_MODE, S_N, S_M, S_K, S_C, S_START, S_SETTLE, S_LOCK
    } state_t;

    state_t                     state;
    logic [17:0]                n_q, m_q;
    logic [31:0]                k_q;
    logic [TW-1:0]              to_cnt;
    logic [SW-1:0]              stab_cnt;
    logic [2:0]                 settle_cnt;
    logic [NUM_CLK-1:0][17:0]   c_word;
    logic [NUM_CLK-1:0]         c_pend, c_rest, c_clr;
    logic [4:0]                 cur_idx, nxt_idx;
    logic [17:0]                cur_word, nxt_word;
    logic                       accept, wr_acc;
    logic [5:0]                 post_addr;
    logic [31:0]                post_data;
    state_t                     post_state;

    assign accept     = (state == S_IDLE) && req_valid;
    assign wr_acc     = mgmt_write && !mgmt_waitrequest;
    assign cfg_locked = pll_locked && !busy;

    // c_rest is the pending set with its lowest channel removed; the difference is
    // the one-hot of the channel currently on the bus
    assign c_rest = c_pend & (c_pend - NUM_CLK'(1));
    assign c_clr  = (state == S_C && wr_acc) ? (c_pend & ~c_rest) : '0;

    generate
        for (genvar g = 0; g < NUM_CLK; g++) begin : g_chan
            pll_reconfig_seq_chan u_chan (
                .refclk  (refclk),
                .rst     (rst),
                .load    (accept),
                .clr     (c_clr[g]),
                .word_in (req_c[18*g +: 18]),
                .mask_in (req_c_mask[g]),
                .word    (c_word[g]),
                .pend    (c_pend[g])
            );
        end
    endgenerate

    // Lowest pending channel now, and lowest after the current one is retired
    always_comb begin
        cur_idx  = '0;
        cur_word = '0;
        nxt_idx  = '0;
        nxt_word = '0;
        for (int i = NUM_CLK - 1; i >= 0; i--) begin
            if (c_pend[i]) begin
                cur_idx  = 5'(i);
                cur_word = c_word[i];
            end
            if (c_rest[i]) begin
                nxt_idx  = 5'(i);
                nxt_word = c_word[i];
            end
        end
    end

    // Write that follows M/K: the first masked-in C channel, or straight to START
    always_comb begin
        if (|c_pend) begin
            post_addr  = A_C;
            post_data  = {9'b0, cur_idx, cur_word};
            post_state = S_C;
        end else begin
            post_addr  = A_START;
            post_data  = 32'd1;
            post_state = S_START;
        end
    end

    // Main sequencer: keeps the write bus registered and stable until accepted, then does lock qualification
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            req_ready      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            mgmt_write     <= 1'b0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
            n_q            <= '0;
            m_q            <= '0;
            k_q            <= '0;
            to_cnt         <= '0;
            stab_cnt       <= '0;
            settle_cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        n_q            <= req_n;
                        m_q            <= req_m;
                        k_q            <= req_k;
                        busy           <= 1'b1;
                        req_ready      <= 1'b0;
                        err            <= 1'b0;
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= A_MODE;
                        mgmt_writedata <= '0;
                        state          <= S_MODE;
                    end
                end
                S_MODE: begin
                    if (wr_acc) begin
                        mgmt_address   <= A_N;
                        mgmt_writedata <= {14'b0, n_q};
                        state          <= S_N;
                    end
                end
                S_N: begin
                    if (wr_acc) begin
                        mgmt_address   <= A_M;
                        mgmt_writedata <= {14'b0, m_q};
                        state          <= S_M;
                    end
                end
                S_M: begin
                    if (wr_acc) begin
                        if (FRAC_EN != 0) begin
                            mgmt_address   <= A_K;
                            mgmt_writedata <= k_q;
                            state          <= S_K;
                        end else begin
                            mgmt_address   <= post_addr;
                            mgmt_writedata <= post_data;
                            state          <= post_state;
                        end
                    end
                end
                S_K: begin
                    if (wr_acc) begin
                        mgmt_address   <= post_addr;
                        mgmt_writedata <= post_data;
                        state          <= post_state;
                    end
                end
                S_C: begin
                    if (wr_acc) begin
                        if (|c_rest) begin
                            mgmt_writedata <= {9'b0, nxt_idx, nxt_word};
                        end else begin
                            mgmt_address   <= A_START;
                            mgmt_writedata <= 32'd1;
                            state          <= S_START;
                        end
                    end
                end
                S_START: begin
                    if (wr_acc) begin
                        mgmt_write <= 1'b0;
                        to_cnt     <= '0;
                        settle_cnt <= '0;
                        stab_cnt   <= '0;
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (to_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else if (settle_cnt == 3'd7) begin
                        state <= S_LOCK;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_LOCK: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (pll_locked && stab_cnt == SW'(LOCK_STABLE - 1)) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else if (to_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        stab_cnt <= pll_locked ? stab_cnt + 1'b1 : '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
Sequencer that drives the Cyclone V PLL reconfiguration controller (Avalon-MM management port) so pixel/video clocks can be retuned at run time. It generalises the fixed single-output fractional PLL wrapper to NUM_CLK output counters. Per request it programs N, M, fractional K and any subset of C counters, issues START, then qualifies lock with a stability window and a timeout. It sits between the video-mode/command logic and the PLL reconfig IP feeding the PLL's reconfig_to_pll/reconfig_from_pll bus.

Parameters:
NUM_CLK, 1, number of C output counters addressable (1..18)
FRAC_EN, 1, 1 = write fractional K register (addr 0x07); 0 = skip it
LOCK_STABLE, 64, consecutive cycles pll_locked must be high before done
LOCK_TIMEOUT, 500000, max cycles from START acceptance to stable lock

Ports:
refclk  in  1  management/reference clock (50 MHz)
rst  in  1  asynchronous active-high reset
req_valid  in  1  new configuration request
req_ready  out  1  high only in IDLE; request taken when req_valid&&req_ready
req_n  in  18  N counter word: [7:0] lo, [15:8] hi, [16] bypass, [17] odd
req_m  in  18  M counter word, same format
req_k  in  32  fractional K value
req_c  in  NUM_CLK*18  C counter words, channel i at [18i+17:18i]
req_c_mask  in  NUM_CLK  1 = program channel i
busy  out  1  high from request accept until done/err
done  out  1  one-cycle pulse on successful lock
err  out  1  sticky lock-timeout flag, cleared on next accepted request
mgmt_address  out  6  Avalon address
mgmt_write  out  1  Avalon write strobe
mgmt_writedata  out  32  Avalon write data
mgmt_waitrequest  in  1  Avalon waitrequest
pll_locked  in  1  raw PLL locked
cfg_locked  out  1  pll_locked qualified: forced 0 while busy

Behaviour:
- Reset (async): IDLE; req_ready=1 after reset release; busy=0, done=0, err=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, counters cleared. Reset mid-write drops mgmt_write immediately; no partial-sequence resume.
- Accept: all req_* fields latched on the accept cycle; inputs ignored afterwards. req_valid while busy is ignored (not queued).
- Write rule: each register write holds mgmt_write/address/data stable until a cycle with mgmt_waitrequest=0 (accept). Next write presented on the following cycle; with waitrequest tied low, writes occur on consecutive cycles starting the cycle after accept.
- States and order: MODE (0x00 <= 0, waitrequest mode) -> N (0x03 <= {14'b0,req_n}) -> M (0x04 <= {14'b0,req_m}) -> K (0x07 <= req_k, only if FRAC_EN) -> C (0x05 <= {9'b0, ch[4:0], c_word}, one write per masked-in channel, ascending index, unmasked channels skipped with zero cycles) -> START (0x02 <= 1) -> SETTLE -> LOCK -> IDLE.
- Mask all zero: C state produces no writes.
- SETTLE: 8 cycles after START accept, pll_locked ignored.
- LOCK: stability counter increments while pll_locked=1, clears to 0 on any low cycle; reaching LOCK_STABLE -> done pulse, busy=0, IDLE.
- Timeout counter starts at START accept, spans SETTLE+LOCK; reaching LOCK_TIMEOUT before stability -> err=1, busy=0, IDLE, no done.
- done and err never both asserted for one request.
- cfg_locked = pll_locked && !busy.
- Counter widths: timeout counter ceil(log2(LOCK_TIMEOUT+1)) bits, stability counter ceil(log2(LOCK_STABLE+1)), channel index 5 bits; no wrap (saturate on terminal event).

Test Plan:
- Basic program, NUM_CLK=1, waitrequest=0, req_n=0x10000, req_m=0x00404, req_k=1182682725, req_c=0x20302, mask=1 -> writes (0x00,0),(0x03,0x00010000),(0x04,0x00000404),(0x07,0x467E4E65),(0x05,0x00020302),(0x02,1) on 6 consecutive cycles; pll_locked high from SETTLE end -> done exactly LOCK_STABLE cycles after SETTLE.
- Waitrequest stall: hold waitrequest=1 for 5 cycles on M write -> address 0x04/data unchanged for those 5 cycles, single accepted write, order preserved.
- NUM_CLK=4, mask=4'b1010 -> C writes only for ch1 (data[22:18]=1) and ch3 (data[22:18]=3); FRAC_EN=0 -> no 0x07 write.
- Lock glitch: pll_locked high 40 cycles, low 1, then high -> done LOCK_STABLE cycles after the glitch; pll_locked never high -> err=1 at LOCK_TIMEOUT, done=0, err cleared on next accept.
- req_valid asserted while busy -> ignored, no extra writes; assert rst during N write -> mgmt_write=0 same cycle, req_ready=1, busy=0 after release.
